// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider with a Start/Busy/Done handshake.
// Produces one quotient bit per clock; divide-by-zero completes in one cycle.
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Start,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic             DivByZero,
    output logic             zero_flag
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] rem;
    logic [CW-1:0]    count;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic             q_bit;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] dividend_next;
    logic             accept;
    logic             last_iter;

    // One restoring step. diff[WIDTH] is the borrow: clear means shifted >= divisor.
    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    always_comb begin
        shifted       = {rem, dividend[WIDTH-1]};
        diff          = shifted - {1'b0, divisor};
        q_bit         = ~diff[WIDTH];
        rem_next      = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
        dividend_next = {dividend[WIDTH-2:0], q_bit};
    end

    assign accept    = Start && ((state == S_IDLE) || (state == S_DONE));
    assign last_iter = (count == CW'(WIDTH - 1));

    // NOTE: state is updated with non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= S_IDLE;
            dividend  <= '0;
            divisor   <= '0;
            rem       <= '0;
            count     <= '0;
            Quotient  <= '0;
            Remainder <= '0;
            DivByZero <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        dividend  <= SrcA;
                        divisor   <= SrcB;
                        rem       <= '0;
                        count     <= '0;
                        DivByZero <= 1'b0;
                        if (SrcB == '0) begin
                            Quotient  <= '1;
                            Remainder <= SrcA;
                            DivByZero <= 1'b1;
                            state     <= S_DONE;
                        end else begin
                            state <= S_RUN;
                        end
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    dividend <= dividend_next;
                    rem      <= rem_next;
                    count    <= count + CW'(1);
                    if (last_iter) begin
                        Quotient  <= dividend_next;
                        Remainder <= rem_next;
                        state     <= S_DONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign Busy      = (state == S_RUN);
    assign Done      = (state == S_DONE);
    assign zero_flag = (Quotient == '0);

endmodule

// File: tb/tb_seq_divider.sv
// Directed and random bench for seq_divider; a queue scoreboard holds the
// expected result of each accepted request until its Done pulse.
module tb_seq_divider;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic        dbz;
    } exp_t;

    logic        CLK = 1'b0;
    logic        RST;
    logic        Start;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic        Busy;
    logic        Done;
    logic [31:0] Quotient;
    logic [31:0] Remainder;
    logic        DivByZero;
    logic        zero_flag;

    int unsigned n_assert = 0;
    int unsigned n_fail   = 0;
    int unsigned cyc      = 0;
    exp_t        sb[$];
    logic [31:0] last_q;
    logic [31:0] last_r;

    seq_divider #(.WIDTH(32)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .Start     (Start),
        .SrcA      (SrcA),
        .SrcB      (SrcB),
        .Busy      (Busy),
        .Done      (Done),
        .Quotient  (Quotient),
        .Remainder (Remainder),
        .DivByZero (DivByZero),
        .zero_flag (zero_flag)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; drives one Start pulse and records the expected result.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input bit push);
        exp_t e;
        Start = 1'b1;
        SrcA  = a;
        SrcB  = b;
        if (push) begin
            e.a   = a;
            e.b   = b;
            e.dbz = (b == 0);
            e.q   = (b == 0) ? 32'hFFFF_FFFF : a / b;
            e.r   = (b == 0) ? a : a % b;
            sb.push_back(e);
        end
        @(negedge CLK);
        Start = 1'b0;
    endtask

    // Waits (bounded) for Done, counting Busy cycles and checking that results hold;
    // optionally injects a Start at loop index inject_at. Returns in the Done cycle.
    task automatic wait_done(input int inject_at, input bit inv_check);
        exp_t e;
        int   busy_n = 0;
        int   n      = 0;
        logic [63:0] recon;
        while (Done !== 1'b1 && n < 100) begin
            if (Busy === 1'b1) busy_n++;
            chk("hold_q", Quotient, last_q);
            chk("hold_r", Remainder, last_r);
            if (n == inject_at) begin
                Start = 1'b1;
                SrcA  = 32'd9;
                SrcB  = 32'd3;
            end else begin
                Start = 1'b0;
            end
            @(negedge CLK);
            n++;
        end
        Start = 1'b0;
        if (sb.size() == 0) begin
            chk("sb_empty", 32'(sb.size()), 32'd1);
            return;
        end
        e = sb.pop_front();
        if (Done !== 1'b1) begin
            chk("done_timeout", {31'b0, Done}, 32'd1);
            return;
        end
        chk("quotient",  Quotient,  e.q);
        chk("remainder", Remainder, e.r);
        chk("div_by_zero", {31'b0, DivByZero}, {31'b0, e.dbz});
        chk("zero_flag", {31'b0, zero_flag}, {31'b0, (e.q == 0)});
        chk("busy_in_done", {31'b0, Busy}, 32'd0);
        chk("busy_cycles", busy_n, e.dbz ? 32'd0 : 32'd32);
        if (inv_check) begin
            recon = 64'(Quotient) * 64'(e.b) + 64'(Remainder);
            chk("invariant", {31'b0, (recon == 64'(e.a))}, 32'd1);
            chk("rem_lt_div", {31'b0, (Remainder < e.b)}, 32'd1);
        end
        last_q = e.q;
        last_r = e.r;
    endtask

    initial begin
        int unsigned prev_done;
        logic [31:0] ra;
        logic [31:0] rb;

        RST    = 1'b1;
        Start  = 1'b0;
        SrcA   = '0;
        SrcB   = '0;
        last_q = '0;
        last_r = '0;
        repeat (2) @(negedge CLK);
        chk("rst_busy", {31'b0, Busy}, 32'd0);
        chk("rst_done", {31'b0, Done}, 32'd0);
        chk("rst_q", Quotient, 32'd0);
        chk("rst_r", Remainder, 32'd0);
        chk("rst_dbz", {31'b0, DivByZero}, 32'd0);
        chk("rst_zf", {31'b0, zero_flag}, 32'd1);
        RST = 1'b0;
        @(negedge CLK);

        // Basic divide.
        issue(32'd100, 32'd7, 1'b1);
        wait_done(-1, 1'b1);

        // Reset mid-run aborts without a Done pulse.
        @(negedge CLK);
        issue(32'd1000, 32'd10, 1'b0);
        repeat (9) @(negedge CLK);
        chk("pre_rst_busy", {31'b0, Busy}, 32'd1);
        RST = 1'b1;
        #1;
        chk("mid_rst_busy", {31'b0, Busy}, 32'd0);
        chk("mid_rst_done", {31'b0, Done}, 32'd0);
        chk("mid_rst_q", Quotient, 32'd0);
        chk("mid_rst_r", Remainder, 32'd0);
        chk("mid_rst_dbz", {31'b0, DivByZero}, 32'd0);
        @(negedge CLK);
        RST    = 1'b0;
        last_q = '0;
        last_r = '0;
        repeat (40) begin
            @(negedge CLK);
            chk("post_rst_no_done", {31'b0, Done}, 32'd0);
        end

        // Edge values.
        issue(32'hFFFF_FFFF, 32'd1, 1'b1);
        wait_done(-1, 1'b1);
        @(negedge CLK);
        issue(32'd5, 32'hFFFF_FFFF, 1'b1);
        wait_done(-1, 1'b1);
        @(negedge CLK);
        issue(32'h8000_0000, 32'h8000_0001, 1'b1);
        wait_done(-1, 1'b1);
        @(negedge CLK);

        // Divide by zero: Done next cycle, Busy never rises.
        issue(32'd123, 32'd0, 1'b1);
        wait_done(-1, 1'b0);
        @(negedge CLK);

        // Start during RUN is ignored.
        issue(32'd1000, 32'd10, 1'b1);
        wait_done(4, 1'b1);
        @(negedge CLK);

        // Back-to-back random: restart in every Done cycle.
        prev_done = 0;
        ra = $urandom;
        rb = $urandom_range(1, 255);
        issue(ra, rb, 1'b1);
        for (int i = 0; i < 1000; i++) begin
            wait_done(-1, 1'b1);
            if (i > 0) chk("done_spacing", cyc - prev_done, 32'd33);
            prev_done = cyc;
            if (i < 999) begin
                ra = $urandom;
                rb = (i % 2 == 0) ? 32'($urandom_range(1, 255)) : $urandom;
                if (rb == 0) rb = 32'd1;
                issue(ra, rb, 1'b1);
            end
        end
        @(negedge CLK);
        chk("idle_after_b2b", {31'b0, Done}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
# seq_divider

Multi-cycle unsigned integer divider that sits beside the single-cycle ALU in the MIPS datapath. It computes the inverse of the ALU's single-cycle multiply: quotient and remainder of SrcA / SrcB, one quotient bit per clock, using restoring shift-subtract. A start/busy/done handshake lets the control unit stall the pipeline until results are valid.

## Interface
- WIDTH, 32: operand and result width in bits.
- CLK  input  1  rising-edge clock.
- RST  input  1  asynchronous reset, active-high.
- Start  input  1  request pulse; sampled on CLK rising edge.
- SrcA  input  WIDTH  dividend, unsigned; sampled only on the accepting edge.
- SrcB  input  WIDTH  divisor, unsigned; sampled only on the accepting edge.
- Busy  output  1  high while a division is in progress (state RUN).
- Done  output  1  single-cycle pulse; results are valid from this cycle onward.
- Quotient  output  WIDTH  registered quotient.
- Remainder  output  WIDTH  registered remainder.
- DivByZero  output  1  registered flag; set when the last accepted SrcB was 0.
- zero_flag  output  1  combinational (Quotient == 0).

## Operation
- States: IDLE, RUN, DONE. Encoding is free.
- The block accepts a request when Start=1 on an edge while in IDLE or DONE. On acceptance it latches SrcA into the dividend shift register and SrcB into the divisor register, clears the partial remainder, clears the iteration counter, and clears DivByZero.
  - If SrcB != 0: next state is RUN.
  - If SrcB == 0: next state is DONE. Quotient = all ones, Remainder = SrcA, DivByZero = 1.
- RUN iteration, once per edge: shift {rem, dividend} left 1. If shifted rem >= divisor, then rem -= divisor and quotient LSB = 1; otherwise LSB = 0.
  - Partial remainder datapath is WIDTH+1 bits so the compare does not overflow.
  - Counter runs from 0 to WIDTH-1. On the edge that performs iteration WIDTH-1, the block writes Quotient and Remainder and moves to DONE.
- DONE lasts exactly one cycle with Done=1. Next state is IDLE unless Start=1, in which case a new request is accepted (back-to-back operation).
- Start is ignored in RUN. Operands are not resampled, and Busy stays high.
- Quotient, Remainder and DivByZero hold their values through IDLE until the next completion. They do not change on acceptance, except that DivByZero clears.
- Invariant: SrcA == Quotient*SrcB + Remainder and Remainder < SrcB, for all SrcB != 0.

## Timing
- Reset (async, RST=1): state IDLE, Busy=0, Done=0, Quotient=0, Remainder=0, DivByZero=0, counter=0. zero_flag=1 as a consequence of Quotient=0.
- RST asserted mid-RUN aborts the operation immediately. Outputs go to their reset values, and no Done is produced.
- Latency, SrcB != 0: Start accepted at edge k. Busy is high from edge k through edge k+WIDTH, so 32 cycles high for WIDTH=32. Done is high for the cycle after edge k+WIDTH, with Busy=0 in that cycle.
- Latency, SrcB == 0: Done is high in the cycle after accepting edge k. Busy never rises.
- Throughput: a new Start in the Done cycle is accepted, so back-to-back divides take WIDTH+1 cycles each.
- Done and Busy are never high in the same cycle.

## Test plan
- Reset: assert RST mid-RUN, 10 cycles after a Start. Required: Busy=0, Done=0, Quotient=0, Remainder=0 immediately. No Done pulse after RST deasserts.
- Basic: SrcA=100, SrcB=7, Start pulse. Required: Busy high for 32 cycles, then Done for 1 cycle with Quotient=14, Remainder=2, DivByZero=0, zero_flag=0.
- Edge values:
  - SrcA=32'hFFFFFFFF, SrcB=1 gives Q=32'hFFFFFFFF, R=0.
  - SrcA=5, SrcB=32'hFFFFFFFF gives Q=0, R=5, zero_flag=1.
  - SrcA=32'h80000000, SrcB=32'h80000001 gives Q=0, R=32'h80000000.
- Divide by zero: SrcA=123, SrcB=0. Required: Done in the next cycle, Q=32'hFFFFFFFF, R=123, DivByZero=1, Busy never high.
- Start during RUN: issue 1000/10, then pulse Start with 9/3 at cycle 5. Required: the second Start is ignored; result is Q=100, R=0 at the original latency.
- Back-to-back and random: assert Start in each Done cycle for 1000 random operand pairs. Required: every result satisfies the invariant, each Done is spaced exactly 33 cycles apart, and outputs hold stable between Done pulses.
